video_fifo_gearbox_prefetch: RTL and testbench
==============================================

Name: video_fifo_gearbox_prefetch

Overview:
- Single-clock, parametrised, width-upsizing prefetch (first-word-fall-through) FIFO for the video write path.
- Packs RATIO narrow pixel words into one wide DDR burst word, with selectable lane order.
- Supports end-of-line flush with zero padding, a synchronous clear, occupancy count and almost-full flag.
- Sits between the pixel-domain line packer and the DDR write-burst master, downstream of the CDC stage.

Parameters:
- WR_DATA_WIDTH, 32, narrow input word width (1..256).
- RATIO, 8, narrow words per wide word; power of 2, 2..32. Output width RD_DATA_WIDTH = WR_DATA_WIDTH*RATIO.
- DEPTH_WIDTH, 8, storage depth is 2^DEPTH_WIDTH wide words (4..12). Total capacity is DEPTH+1 words, counting the prefetch register.
- AF_LEVEL, 240, word_cnt threshold for almost_full (1..DEPTH).
- LANE_ORDER, "LSB_FIRST", "LSB_FIRST": first narrow word lands in bits [WR_DATA_WIDTH-1:0]. "MSB_FIRST": first narrow word lands in the top lane.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear; same effect as reset, takes priority over all other inputs
- wr_en  in  1  write request; a lane is accepted when wr_en && wr_vld
- wr_data  in  WR_DATA_WIDTH  narrow write data
- wr_vld  out  1  ready to accept a narrow word
- flush  in  1  single-cycle pulse: commit the partial wide word, zero-padded
- rd_en  in  1  pop; a word is consumed when rd_en && rd_vld
- rd_vld  out  1  rd_data is valid (FWFT)
- rd_data  out  RD_DATA_WIDTH  wide read data, held stable while rd_vld && !rd_en
- wr_lane  out  clog2(RATIO)  index of the next lane to be filled
- word_cnt  out  DEPTH_WIDTH+1  committed wide words (storage + prefetch register)
- almost_full  out  1  word_cnt >= AF_LEVEL, registered

Behaviour:
- Reset/clr values: wr_vld=1, rd_vld=0, rd_data=0, wr_lane=0, word_cnt=0, almost_full=0. Pack register, flush_pend and pointers are also zeroed.
- Pack:
  - An accepted lane is written into pack lane wr_lane; wr_lane then increments modulo RATIO.
  - When the lane with index RATIO-1 is accepted, {pack, incoming lane} is written to storage on the same edge, and the pack register is cleared.
- Storage: dual-port RAM of 2^DEPTH_WIDTH words with wrap-around write/read pointers and one extra pointer bit for full/empty.
- Prefetch:
  - The output register loads from storage whenever storage is non-empty and (!rd_vld || rd_en).
  - Latency: final lane accepted in cycle N → rd_vld=1 in cycle N+2 when the FIFO was empty.
  - Back-to-back reads at one word per clock are sustained while storage is non-empty.
- wr_vld = !flush_pend && (storage_not_full || wr_lane != RATIO-1). Partial lanes may still be filled while storage is full.
- Flush:
  - flush with wr_lane==0 and no write in the same cycle: no effect.
  - Otherwise the current pack, including any lane accepted in the same cycle, is committed with unfilled lanes = 0, and wr_lane returns to 0.
  - If flush arrives in the same cycle as a final-lane write, that completes the word normally and no extra word is produced.
  - If storage is full at flush time, flush_pend is set, wr_vld drops, and the commit happens on the first cycle storage has room. Further flush pulses while pending are ignored.
- word_cnt:
  - Increments on each commit to storage and decrements on each read consumption.
  - A simultaneous commit and consume leaves it unchanged.
  - Maximum value is DEPTH+1.
- Read while empty (rd_en && !rd_vld) is ignored; no state changes.
- almost_full is updated from the next-state value of word_cnt.

Test Plan:
- LSB_FIRST: write 0x00..0x07 (RATIO=8) back-to-back, rd_en=0 → wr_lane cycles 0..7→0. rd_vld rises 2 clocks after the 8th accept, rd_data=0x00000007_..._00000000, word_cnt=1.
- Fill with rd_en=0: write 257 complete words → wr_vld=0 exactly when wr_lane=7 with storage full. Lanes 0..6 of word 258 are still accepted. almost_full=1 from word_cnt=240. One rd_en pop → wr_vld=1 the next cycle.
- Flush with 3 lanes (0xA,0xB,0xC) → one word committed, lanes 3..7 = 0, wr_lane=0. A second flush with wr_lane=0 → word_cnt unchanged.
- Flush while storage full with 2 partial lanes → wr_vld=0 and flush_pend held. After one pop, the padded word commits the next cycle and wr_vld returns to 1.
- Steady state with continuous rd_en=1 and writes at the full rate → one wide word out per 8 input clocks, no gaps, no lost or duplicated words (scoreboard over 10,000 words, random rd_en stalls included).
- Mid-operation: assert rst_n=0 asynchronously, then repeat with clr=1, in each case with 5 words and 3 lanes pending → all outputs return to their reset values immediately (rst_n) or on the next edge (clr), and no stale data appears afterwards. Rerun the LSB_FIRST case with LANE_ORDER="MSB_FIRST" → rd_data=0x00000000_..._00000007.

Source files
------------

// File: rtl/video_fifo_gearbox_prefetch_if.sv
// Handshake bundle for the width-upsizing prefetch FIFO.
// The slave side is the FIFO; the master side is the producer/consumer pair.
interface video_fifo_gearbox_prefetch_if #(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RATIO         = 8,
  parameter int DEPTH_WIDTH   = 8
);
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;
  localparam int LANE_W        = $clog2(RATIO);

  logic                     wr_en;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     wr_vld;
  logic                     flush;
  logic                     rd_en;
  logic                     rd_vld;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic [LANE_W-1:0]        wr_lane;
  logic [DEPTH_WIDTH:0]     word_cnt;
  logic                     almost_full;

  modport master (
    output wr_en, wr_data, flush, rd_en,
    input  wr_vld, rd_vld, rd_data, wr_lane, word_cnt, almost_full
  );

  modport slave (
    input  wr_en, wr_data, flush, rd_en,
    output wr_vld, rd_vld, rd_data, wr_lane, word_cnt, almost_full
  );
endinterface

// File: rtl/video_fifo_gearbox_prefetch.sv
// Width-upsizing FWFT FIFO: packs RATIO narrow pixel words into one wide DDR word,
// with zero-padded end-of-line flush, synchronous clear, occupancy and almost-full.

module video_fifo_gearbox_prefetch_lane #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_clear,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_nxt
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_q <= '0;
    else if (i_clr || i_clear)  r_q <= '0;
    else if (i_we)              r_q <= i_d;
  end

  // Same-cycle bypass so a commit includes the lane accepted on that edge.
  assign o_nxt = i_we ? i_d : r_q;
endmodule

module video_fifo_gearbox_prefetch #(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RATIO         = 8,
  parameter int DEPTH_WIDTH   = 8,
  parameter int AF_LEVEL      = 240,
  parameter     LANE_ORDER    = "LSB_FIRST"
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clr,
  video_fifo_gearbox_prefetch_if.slave  bus
);
  localparam int RD_W   = WR_DATA_WIDTH * RATIO;
  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam bit MSB    = (LANE_ORDER == "MSB_FIRST");
  localparam logic [LANE_W-1:0]    LAST = LANE_W'(RATIO - 1);
  localparam logic [DEPTH_WIDTH:0] ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH:0] AFL  = (DEPTH_WIDTH+1)'(AF_LEVEL);

  logic [LANE_W-1:0]                   r_wr_lane;
  logic [DEPTH_WIDTH:0]                r_wptr, r_rptr, r_word_cnt, w_cnt_nxt;
  logic                                r_flush_pend, r_rd_vld, r_af;
  logic [RD_W-1:0]                     r_rd_data;
  logic [RD_W-1:0]                     r_mem [DEPTH];
  logic [RATIO-1:0][WR_DATA_WIDTH-1:0] w_pack_nxt;
  logic [RATIO-1:0]                    w_lane_we;

  logic w_full, w_empty, w_wr_vld, w_acc, w_last;
  logic w_flush_req, w_commit, w_pend_set, w_pop, w_load;

  assign w_full  = (r_wptr[DEPTH_WIDTH] != r_rptr[DEPTH_WIDTH]) &&
                   (r_wptr[DEPTH_WIDTH-1:0] == r_rptr[DEPTH_WIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // Partial lanes stay writable while storage is full; only the completing lane stalls.
  assign w_wr_vld    = !r_flush_pend && (!w_full || r_wr_lane != LAST);
  assign w_acc       = bus.wr_en && w_wr_vld;
  assign w_last      = w_acc && (r_wr_lane == LAST);
  assign w_flush_req = bus.flush && !r_flush_pend && !w_last && (r_wr_lane != '0 || w_acc);
  assign w_commit    = w_last || ((w_flush_req || r_flush_pend) && !w_full);
  assign w_pend_set  = w_flush_req && w_full;
  assign w_pop       = bus.rd_en && r_rd_vld;
  assign w_load      = !w_empty && (!r_rd_vld || bus.rd_en);

  genvar g;
  generate
    for (g = 0; g < RATIO; g++) begin : g_lane
      localparam int LIDX = MSB ? (RATIO - 1 - g) : g;
      assign w_lane_we[g] = w_acc && (r_wr_lane == LANE_W'(LIDX));
      video_fifo_gearbox_prefetch_lane #(.W(WR_DATA_WIDTH)) u_lane (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .i_clear (w_commit),
        .i_we    (w_lane_we[g]),
        .i_d     (bus.wr_data),
        .o_nxt   (w_pack_nxt[g])
      );
    end
  endgenerate

  always_comb begin
    w_cnt_nxt = r_word_cnt;
    case ({w_commit, w_pop})
      2'b10:   w_cnt_nxt = r_word_cnt + ONE;
      2'b01:   w_cnt_nxt = r_word_cnt - ONE;
      default: w_cnt_nxt = r_word_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_commit && !i_clr) r_mem[r_wptr[DEPTH_WIDTH-1:0]] <= w_pack_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_lane    <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_data    <= '0;
      r_af         <= 1'b0;
    end else if (i_clr) begin
      r_wr_lane    <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_data    <= '0;
      r_af         <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wptr    <= r_wptr + ONE;
        r_wr_lane <= '0;
      end else if (w_acc) begin
        r_wr_lane <= r_wr_lane + LANE_W'(1);
      end

      if (w_commit)        r_flush_pend <= 1'b0;
      else if (w_pend_set) r_flush_pend <= 1'b1;

      if (w_load) begin
        r_rd_data <= r_mem[r_rptr[DEPTH_WIDTH-1:0]];
        r_rd_vld  <= 1'b1;
        r_rptr    <= r_rptr + ONE;
      end else if (w_pop) begin
        r_rd_vld  <= 1'b0;
      end

      r_word_cnt <= w_cnt_nxt;
      r_af       <= (w_cnt_nxt >= AFL);
    end
  end

  assign bus.wr_vld      = w_wr_vld;
  assign bus.rd_vld      = r_rd_vld;
  assign bus.rd_data     = r_rd_data;
  assign bus.wr_lane     = r_wr_lane;
  assign bus.word_cnt    = r_word_cnt;
  assign bus.almost_full = r_af;
endmodule

// File: tb/tb_video_fifo_gearbox_prefetch.sv
// Directed bench for the gearbox FIFO: packing order, fill/full, flush, streaming, reset/clear.
module tb_video_fifo_gearbox_prefetch;
  logic clk = 1'b0;
  logic rst_n, clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  video_fifo_gearbox_prefetch_if #(.WR_DATA_WIDTH(32), .RATIO(8), .DEPTH_WIDTH(8)) if_l ();
  video_fifo_gearbox_prefetch_if #(.WR_DATA_WIDTH(32), .RATIO(8), .DEPTH_WIDTH(8)) if_m ();

  assign if_m.wr_en   = if_l.wr_en;
  assign if_m.wr_data = if_l.wr_data;
  assign if_m.flush   = if_l.flush;
  assign if_m.rd_en   = if_l.rd_en;

  video_fifo_gearbox_prefetch #(.WR_DATA_WIDTH(32), .RATIO(8), .DEPTH_WIDTH(8),
    .AF_LEVEL(240), .LANE_ORDER("LSB_FIRST")) u_dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_l.slave));

  video_fifo_gearbox_prefetch #(.WR_DATA_WIDTH(32), .RATIO(8), .DEPTH_WIDTH(8),
    .AF_LEVEL(240), .LANE_ORDER("MSB_FIRST")) u_dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(if_m.slave));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_wr_vld"},   if_l.wr_vld,      1);
    chk({tag, "_rd_vld"},   if_l.rd_vld,      0);
    chk({tag, "_rd_data"},  if_l.rd_data,     0);
    chk({tag, "_wr_lane"},  if_l.wr_lane,     0);
    chk({tag, "_word_cnt"}, if_l.word_cnt,    0);
    chk({tag, "_af"},       if_l.almost_full, 0);
  endtask

  initial begin
    logic [255:0]        last_w, acc_w, exp_w;
    logic [255:0]        expq[$];
    int                  bad, afbad, npop, sberr, gapbad, nwr, lane_i, k;

    rst_n = 1'b0; clr = 1'b0;
    if_l.wr_en = 1'b0; if_l.wr_data = '0; if_l.flush = 1'b0; if_l.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;

    // Lane order: 0..7 into one word
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lane_seq", if_l.wr_lane, i);
      if_l.wr_en = 1'b1; if_l.wr_data = i;
    end
    @(negedge clk);
    if_l.wr_en = 1'b0;
    chk("lane_wrap", if_l.wr_lane, 0);
    chk("lat_n1_rd_vld", if_l.rd_vld, 0);
    chk("cnt_one", if_l.word_cnt, 1);
    @(negedge clk);
    chk("lat_n2_rd_vld", if_l.rd_vld, 1);
    chk("lsb_data", if_l.rd_data,
        256'h0000000700000006000000050000000400000003000000020000000100000000);
    chk("msb_data", if_m.rd_data,
        256'h0000000000000001000000020000000300000004000000050000000600000007);
    if_l.rd_en = 1'b1;
    @(negedge clk);
    if_l.rd_en = 1'b0;
    chk("pop_rd_vld", if_l.rd_vld, 0);
    chk("pop_cnt", if_l.word_cnt, 0);

    // Flush with 3 lanes, then an empty flush, then flush with same-cycle write
    if_l.wr_en = 1'b1; if_l.wr_data = 32'hA;
    @(negedge clk); if_l.wr_data = 32'hB;
    @(negedge clk); if_l.wr_data = 32'hC;
    @(negedge clk); if_l.wr_en = 1'b0; if_l.flush = 1'b1;
    chk("fl_lane3", if_l.wr_lane, 3);
    @(negedge clk); if_l.flush = 1'b0;
    chk("fl_lane0", if_l.wr_lane, 0);
    chk("fl_cnt", if_l.word_cnt, 1);
    @(negedge clk);
    chk("fl_rd_vld", if_l.rd_vld, 1);
    chk("fl_data", if_l.rd_data, 256'h0000000C0000000B0000000A);
    if_l.flush = 1'b1;
    @(negedge clk); if_l.flush = 1'b0;
    @(negedge clk);
    chk("fl_empty_cnt", if_l.word_cnt, 1);
    if_l.wr_en = 1'b1; if_l.wr_data = 32'hD; if_l.flush = 1'b1;
    @(negedge clk); if_l.wr_en = 1'b0; if_l.flush = 1'b0;
    chk("flw_cnt", if_l.word_cnt, 2);
    chk("flw_lane", if_l.wr_lane, 0);
    if_l.rd_en = 1'b1;
    @(negedge clk);
    chk("flw_data", if_l.rd_data, 256'hD);
    chk("flw_cnt1", if_l.word_cnt, 1);
    @(negedge clk); if_l.rd_en = 1'b0;
    chk("flw_empty", if_l.rd_vld, 0);
    chk("flw_cnt0", if_l.word_cnt, 0);

    // Fill: 257 complete words with no reads
    bad = 0; afbad = 0;
    for (int w = 0; w < 257; w++) begin
      for (int l = 0; l < 8; l++) begin
        if_l.wr_en = 1'b1; if_l.wr_data = w * 8 + l;
        if (if_l.wr_vld !== 1'b1) bad++;
        if (if_l.almost_full !== (if_l.word_cnt >= 240)) afbad++;
        @(negedge clk);
      end
    end
    if_l.wr_en = 1'b0;
    chk("fill_wr_vld", bad, 0);
    chk("fill_af_track", afbad, 0);
    @(negedge clk);
    chk("fill_cnt", if_l.word_cnt, 257);
    chk("fill_af", if_l.almost_full, 1);
    bad = 0;
    for (int l = 0; l < 7; l++) begin
      if_l.wr_en = 1'b1; if_l.wr_data = 32'hF00 + l;
      if (if_l.wr_vld !== 1'b1) bad++;
      @(negedge clk);
    end
    if_l.wr_en = 1'b0;
    chk("full_partial_acc", bad, 0);
    chk("full_lane7", if_l.wr_lane, 7);
    chk("full_wr_vld", if_l.wr_vld, 0);
    if_l.wr_en = 1'b1; if_l.wr_data = 32'hF07;
    @(negedge clk); if_l.wr_en = 1'b0;
    chk("full_blocked_lane", if_l.wr_lane, 7);
    chk("full_blocked_cnt", if_l.word_cnt, 257);
    if_l.rd_en = 1'b1;
    @(negedge clk); if_l.rd_en = 1'b0;
    chk("pop_wr_vld", if_l.wr_vld, 1);
    chk("pop_cnt256", if_l.word_cnt, 256);
    chk("pop_next_data", if_l.rd_data,
        256'h0000000F0000000E0000000D0000000C0000000B0000000A0000000900000008);
    if_l.wr_en = 1'b1; if_l.wr_data = 32'hF07;
    @(negedge clk); if_l.wr_en = 1'b0;
    chk("refill_cnt", if_l.word_cnt, 257);
    chk("refill_lane", if_l.wr_lane, 0);

    // Flush while storage is full
    if_l.wr_en = 1'b1; if_l.wr_data = 32'hE1;
    @(negedge clk); if_l.wr_data = 32'hE2;
    @(negedge clk); if_l.wr_en = 1'b0; if_l.flush = 1'b1;
    @(negedge clk); if_l.flush = 1'b0;
    chk("pend_wr_vld", if_l.wr_vld, 0);
    chk("pend_lane", if_l.wr_lane, 2);
    chk("pend_cnt", if_l.word_cnt, 257);
    if_l.flush = 1'b1;
    @(negedge clk); if_l.flush = 1'b0;
    @(negedge clk);
    chk("pend_hold", if_l.wr_vld, 0);
    if_l.rd_en = 1'b1;
    @(negedge clk); if_l.rd_en = 1'b0;
    chk("pend_pop_wr_vld", if_l.wr_vld, 0);
    chk("pend_pop_cnt", if_l.word_cnt, 256);
    @(negedge clk);
    chk("pend_commit_wr_vld", if_l.wr_vld, 1);
    chk("pend_commit_cnt", if_l.word_cnt, 257);
    chk("pend_commit_lane", if_l.wr_lane, 0);
    npop = 0; last_w = '0;
    if_l.rd_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!if_l.rd_vld) break;
      last_w = if_l.rd_data; npop++;
      @(negedge clk);
    end
    if_l.rd_en = 1'b0;
    chk("drain_count", npop, 257);
    chk("drain_last", last_w, 256'h000000E2000000E1);
    chk("drain_cnt", if_l.word_cnt, 0);
    chk("drain_af", if_l.almost_full, 0);

    // Streaming scoreboard: full-rate writes, rd_en continuous then randomly stalled
    nwr = 0; npop = 0; sberr = 0; gapbad = 0; lane_i = 0; k = 0; acc_w = '0;
    for (int c = 0; c < 20000 && nwr < 600; c++) begin
      if_l.rd_en   = (nwr < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if_l.wr_en   = 1'b1;
      if_l.wr_data = 32'h1000_0000 + k;
      if (if_l.wr_vld === 1'b1) begin
        acc_w[lane_i*32 +: 32] = if_l.wr_data;
        k++; lane_i++;
        if (lane_i == 8) begin expq.push_back(acc_w); acc_w = '0; lane_i = 0; nwr++; end
      end else if (nwr < 100) gapbad++;
      if (if_l.rd_en && if_l.rd_vld === 1'b1) begin
        if (expq.size() == 0) sberr++;
        else begin exp_w = expq.pop_front(); if (if_l.rd_data !== exp_w) sberr++; npop++; end
      end
      @(negedge clk);
    end
    if_l.wr_en = 1'b0; if_l.rd_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (if_l.rd_vld === 1'b1) begin
        if (expq.size() == 0) sberr++;
        else begin exp_w = expq.pop_front(); if (if_l.rd_data !== exp_w) sberr++; npop++; end
      end
      @(negedge clk);
    end
    if_l.rd_en = 1'b0;
    chk("stream_written", nwr, 600);
    chk("stream_sb_err", sberr, 0);
    chk("stream_popped", npop, 600);
    chk("stream_leftover", expq.size(), 0);
    chk("stream_no_gap", gapbad, 0);

    // Asynchronous reset mid-operation: 5 words + 3 lanes pending
    for (int i = 0; i < 43; i++) begin
      if_l.wr_en = 1'b1; if_l.wr_data = 32'h5000 + i;
      @(negedge clk);
    end
    if_l.wr_en = 1'b0;
    @(negedge clk);
    chk("pre_arst_cnt", if_l.word_cnt, 5);
    #2 rst_n = 1'b0;
    #1 chk_rst("arst");
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_stale_vld", if_l.rd_vld, 0);
    chk("arst_stale_cnt", if_l.word_cnt, 0);
    if_l.wr_en = 1'b1; if_l.wr_data = 32'h55; if_l.flush = 1'b1;
    @(negedge clk); if_l.wr_en = 1'b0; if_l.flush = 1'b0;
    @(negedge clk);
    chk("arst_new_vld", if_l.rd_vld, 1);
    chk("arst_new_data", if_l.rd_data, 256'h55);
    chk("arst_new_cnt", if_l.word_cnt, 1);

    // Synchronous clear mid-operation, with competing inputs in the same cycle
    for (int i = 0; i < 43; i++) begin
      if_l.wr_en = 1'b1; if_l.wr_data = 32'h6000 + i;
      @(negedge clk);
    end
    if_l.wr_en = 1'b0;
    @(negedge clk);
    chk("pre_clr_cnt", if_l.word_cnt, 6);
    clr = 1'b1; if_l.wr_en = 1'b1; if_l.wr_data = 32'h77; if_l.flush = 1'b1; if_l.rd_en = 1'b1;
    #2 chk("clr_waits_edge", if_l.word_cnt, 6);
    @(negedge clk);
    clr = 1'b0; if_l.wr_en = 1'b0; if_l.flush = 1'b0; if_l.rd_en = 1'b0;
    chk_rst("clr");
    repeat (3) @(negedge clk);
    chk("clr_stale_vld", if_l.rd_vld, 0);
    if_l.wr_en = 1'b1; if_l.wr_data = 32'h66; if_l.flush = 1'b1;
    @(negedge clk); if_l.wr_en = 1'b0; if_l.flush = 1'b0;
    @(negedge clk);
    chk("clr_new_data", if_l.rd_data, 256'h66);
    chk("clr_new_cnt", if_l.word_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
